// File: rtl/acia_tx.sv
// UART 8N1 transmitter with a small byte FIFO; shares the bit-rate
// parameters with acia_rx so one setting configures both directions.
module acia_tx #(
  parameter int unsigned SCW     = 16,
  parameter int unsigned sym_cnt = 40000,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_dat,
  input  logic       tx_stb,
  output logic       tx_rdy,
  output logic       tx_ovf,
  output logic       tx_busy,
  output logic       tx_serial
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam logic [SCW-1:0] TERM = SCW'(sym_cnt - 1);
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_nxt;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [SCW-1:0]       rate_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shift_q, shift_nxt;
  logic                 serial_nxt;
  logic                 push, pop, fifo_ne, tick;

  assign tx_rdy  = (count != FULL);
  assign fifo_ne = (count != '0);
  assign push    = tx_stb && tx_rdy;
  assign tick    = (rate_cnt == TERM);
  assign tx_busy = (state_q != IDLE) || fifo_ne;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (fifo_ne) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (tick) state_nxt = fifo_ne ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: FIFO pop, next shift contents and the next line level
  always_comb begin
    pop        = 1'b0;
    shift_nxt  = shift_q;
    serial_nxt = 1'b1;
    case (state_q)
      IDLE:    pop = fifo_ne;
      DATA:    if (tick) shift_nxt = {1'b0, shift_q[7:1]};
      STOP:    pop = tick && fifo_ne;
      default: ;
    endcase
    if (pop) shift_nxt = mem[rd_ptr];
    case (state_nxt)
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = shift_nxt[0];
      default: serial_nxt = 1'b1;
    endcase
  end

  // Datapath: rate/bit counters, shifter, line register, FIFO bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_serial <= 1'b1;
      tx_ovf    <= 1'b0;
      shift_q   <= '0;
      rate_cnt  <= '0;
      bit_idx   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      tx_serial <= serial_nxt;
      tx_ovf    <= tx_stb && !tx_rdy;
      shift_q   <= shift_nxt;
      rate_cnt  <= (state_q == IDLE || tick) ? '0 : rate_cnt + SCW'(1);
      if (pop)
        bit_idx <= '0;
      else if (state_q == DATA && tick)
        bit_idx <= bit_idx + 3'd1;
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage needs no reset; count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_dat;
  end

endmodule

// File: tb/tb_acia_tx.sv
// Directed bench for acia_tx at 4 clocks per bit: frame timing, back-to-back
// frames, overflow, FIFO wrap with concurrent push/pop, and mid-frame reset.
module tb_acia_tx;

  localparam int unsigned SYM = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_dat;
  logic       tx_stb;
  logic       tx_rdy, tx_ovf, tx_busy, tx_serial;

  int n_checks = 0;
  int n_fail   = 0;
  int wk;
  int lows;
  logic [7:0] rb;

  typedef struct {
    logic [7:0] dat;
    logic [9:0] frame;   // {stop, d7..d0, start}; bit i is line level in bit period i
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] wrap_bytes [20];

  always #5 clk = ~clk;

  acia_tx #(.SCW(4), .sym_cnt(SYM), .FIFO_AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_dat    (tx_dat),
    .tx_stb    (tx_stb),
    .tx_rdy    (tx_rdy),
    .tx_ovf    (tx_ovf),
    .tx_busy   (tx_busy),
    .tx_serial (tx_serial)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called on the negedge just after the start-bit edge; returns 40 cycles later.
  task automatic check_frame(input logic [9:0] f, input string tag);
    for (int j = 0; j < 10 * SYM; j++) begin
      chk($sformatf("%s line j=%0d", tag, j), 32'(tx_serial), 32'(f[j / SYM]));
      if (j == 0 || j == 10 * SYM - 1)
        chk($sformatf("%s busy j=%0d", tag, j), 32'(tx_busy), 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic send_one(input logic [7:0] d, input logic [9:0] f, input string tag);
    tx_dat = d;
    tx_stb = 1'b1;
    chk({tag, " rdy"}, 32'(tx_rdy), 32'd1);
    @(negedge clk);
    tx_stb = 1'b0;
    chk({tag, " line before pop"}, 32'(tx_serial), 32'd1);
    chk({tag, " busy after push"}, 32'(tx_busy), 32'd1);
    @(negedge clk);
    check_frame(f, tag);
    chk({tag, " busy after frame"}, 32'(tx_busy), 32'd0);
    chk({tag, " idle line"}, 32'(tx_serial), 32'd1);
  endtask

  // Mid-bit sampling receiver with a bounded wait for the start bit.
  task automatic rx_byte(output logic [7:0] b, input string tag);
    int w;
    w = 0;
    b = '0;
    while (tx_serial !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " start seen"}, 32'(tx_serial), 32'd0);
    if (tx_serial !== 1'b0) return;
    repeat (2) @(negedge clk);
    chk({tag, " start mid"}, 32'(tx_serial), 32'd0);
    for (int n = 0; n < 8; n++) begin
      repeat (SYM) @(negedge clk);
      b[n] = tx_serial;
    end
    repeat (SYM) @(negedge clk);
    chk({tag, " stop mid"}, 32'(tx_serial), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h55, 10'b1_0101_0101_0};
    vecs[1] = '{8'hA5, 10'b1_1010_0101_0};
    vecs[2] = '{8'h3C, 10'b1_0011_1100_0};
    vecs[3] = '{8'h00, 10'b1_0000_0000_0};
    vecs[4] = '{8'hFF, 10'b1_1111_1111_0};
    vecs[5] = '{8'h7E, 10'b1_0111_1110_0};
    vecs[6] = '{8'h01, 10'b1_0000_0001_0};
    for (int i = 0; i < 20; i++) wrap_bytes[i] = 8'(i * 37 + 5);

    rst    = 1'b1;
    tx_stb = 1'b0;
    tx_dat = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset serial", 32'(tx_serial), 32'd1);
    chk("reset busy",   32'(tx_busy),   32'd0);
    chk("reset rdy",    32'(tx_rdy),    32'd1);
    chk("reset ovf",    32'(tx_ovf),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single frames from the vector table
    for (int i = 0; i < 7; i++)
      send_one(vecs[i].dat, vecs[i].frame, $sformatf("vec%0d", i));

    // Back-to-back: A5 then 3C on consecutive cycles, no idle gap between frames
    tx_dat = 8'hA5; tx_stb = 1'b1;
    @(negedge clk);
    tx_dat = 8'h3C;
    @(negedge clk);
    tx_stb = 1'b0;
    check_frame(vecs[1].frame, "b2b first");
    check_frame(vecs[2].frame, "b2b second");
    chk("b2b busy end", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);

    // Overflow: 10 strobes into depth 8 while the first byte is popped at edge 1
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          tx_dat = 8'h10 + 8'(i);
          tx_stb = 1'b1;
          chk($sformatf("ovf rdy%0d", i), 32'(tx_rdy), (i == 9) ? 32'd0 : 32'd1);
          chk($sformatf("ovf quiet%0d", i), 32'(tx_ovf), 32'd0);
          @(negedge clk);
        end
        tx_stb = 1'b0;
        chk("ovf pulse", 32'(tx_ovf), 32'd1);
        @(negedge clk);
        chk("ovf one cycle", 32'(tx_ovf), 32'd0);
      end
      begin
        for (int i = 0; i < 9; i++) begin
          rx_byte(rb, $sformatf("ovf rx%0d", i));
          chk($sformatf("ovf byte%0d", i), 32'(rb), 32'(8'h10 + 8'(i)));
        end
      end
    join
    repeat (2) @(negedge clk);
    chk("ovf busy end", 32'(tx_busy), 32'd0);
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      if (tx_serial !== 1'b1) lows++;
      @(negedge clk);
    end
    chk("dropped byte never sent", 32'(lows), 32'd0);

    // Wrap: 3 held entries, pushes land on the STOP->START pop edge, 20 bytes total
    wk = 0;
    fork
      begin
        for (int c = 0; c <= 1 + 40 * 16; c++) begin
          if (c < 4 || (c >= 41 && (c - 1) % 40 == 0)) begin
            tx_dat = wrap_bytes[wk];
            wk++;
            tx_stb = 1'b1;
            chk($sformatf("wrap rdy c=%0d", c), 32'(tx_rdy), 32'd1);
          end else begin
            tx_stb = 1'b0;
          end
          @(negedge clk);
        end
        tx_stb = 1'b0;
      end
      begin
        for (int i = 0; i < 20; i++) begin
          rx_byte(rb, $sformatf("wrap rx%0d", i));
          chk($sformatf("wrap byte%0d", i), 32'(rb), 32'(wrap_bytes[i]));
        end
      end
    join
    repeat (2) @(negedge clk);
    chk("wrap busy end", 32'(tx_busy), 32'd0);

    // Reset during data bit 3 of 0xC3 with 0x99 still queued
    tx_dat = 8'hC3; tx_stb = 1'b1;
    @(negedge clk);
    tx_dat = 8'h99;
    @(negedge clk);
    tx_stb = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre-reset bit3 low", 32'(tx_serial), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async rst serial", 32'(tx_serial), 32'd1);
    chk("async rst busy",   32'(tx_busy),   32'd0);
    chk("async rst rdy",    32'(tx_rdy),    32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int c = 0; c < 50; c++) begin
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) lows++;
      @(negedge clk);
    end
    chk("queue flushed by reset", 32'(lows), 32'd0);
    send_one(8'h01, vecs[6].frame, "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
